// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, data width and bit-timing helper (PARITY state only with UART_RX_PARITY_EN)
package uart_pkg;
    localparam int DATA_BITS = 8;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: loadable down-counter; tick fires exactly load_val cycles after a load
module uart_baud_cnt #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - W'(1);
    end
    // ticking at 1 (not 0) makes the reload cycle part of the period
    assign tick = cnt == W'(1);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling; even parity and rx_parity_err when UART_RX_PARITY_EN is defined
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       UART_RXD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       rx_parity_err,
`endif
    output logic       rx_busy
);
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(CPB + 1);
    logic                 s1, s2, rx_d;
    logic [1:0]           warm;
    state_t               state, state_nx;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic [2:0]           idx, idx_nx;
    logic                 tick, load, valid_nx, ferr_nx;
    logic [CW-1:0]        load_val;
`ifdef UART_RX_PARITY_EN
    logic                 perr, perr_nx, perr_out_nx;
`endif
    uart_baud_cnt #(.W(CW)) u_baud (
        .clk     (CLOCK_50),
        .rst     (reset),
        .load    (load),
        .load_val(load_val),
        .tick    (tick)
    );
    // edge history stays low until the synchronizer holds real line samples,
    // so a line already low at reset release never looks like a start bit
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1           <= 1'b1;
            s2           <= 1'b1;
            rx_d         <= 1'b0;
            warm         <= 2'b00;
            state        <= IDLE;
            shift        <= '0;
            idx          <= '0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr          <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            s1           <= UART_RXD;
            s2           <= s1;
            warm         <= {warm[0], 1'b1};
            rx_d         <= s2 & warm[1];
            state        <= state_nx;
            shift        <= shift_nx;
            idx          <= idx_nx;
            rx_valid     <= valid_nx;
            rx_frame_err <= ferr_nx;
            if (valid_nx) rx_data <= shift;
`ifdef UART_RX_PARITY_EN
            perr          <= perr_nx;
            rx_parity_err <= perr_out_nx;
`endif
        end
    end
    always_comb begin
        state_nx = state;
        shift_nx = shift;
        idx_nx   = idx;
        load     = 1'b0;
        load_val = (state == IDLE) ? CW'(CPB / 2) : CW'(CPB);
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_nx     = perr;
        perr_out_nx = 1'b0;
`endif
        case (state)
            IDLE: if (rx_d & ~s2) begin
                state_nx = START;
                load     = 1'b1;
            end
            START: if (tick) begin
                state_nx = s2 ? IDLE : DATA;
                idx_nx   = '0;
                load     = 1'b1;
            end
            DATA: if (tick) begin
                shift_nx = {s2, shift[DATA_BITS-1:1]};
                idx_nx   = idx + 3'd1;
                load     = 1'b1;
`ifdef UART_RX_PARITY_EN
                if (idx == 3'(DATA_BITS - 1)) state_nx = PARITY;
`else
                if (idx == 3'(DATA_BITS - 1)) state_nx = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                perr_nx  = s2 ^ (^shift);
                load     = 1'b1;
                state_nx = STOP;
            end
            STOP: if (tick) begin
                state_nx    = s2 ? IDLE : WAIT_IDLE;
                valid_nx    = s2 & ~perr;
                ferr_nx     = ~s2;
                perr_out_nx = perr;
            end
`else
            STOP: if (tick) begin
                state_nx = s2 ? IDLE : WAIT_IDLE;
                valid_nx = s2;
                ferr_nx  = ~s2;
            end
`endif
            WAIT_IDLE: if (s2) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    assign rx_busy = state != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus against a byte-queue scoreboard and frame-timing reference
module tb_uart_rx;
    localparam int CPB = 50000000 / 115200;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int EXP_LAT = 2 + CPB / 2 + (NBITS - 1) * CPB + 1;
    logic       CLOCK_50 = 1'b0, reset = 1'b1, UART_RXD = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_busy;
    int         checks = 0, failures = 0, cyc = 0, start_cyc = 0, last_valid_cyc = 0;
    int         nvalid = 0, nferr = 0, nperr = 0, v0, f0, p0;
    logic [7:0] exp_q[$];
    logic [7:0] rnd;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif
    uart_rx dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .UART_RXD    (UART_RXD),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
`ifdef UART_RX_PARITY_EN
        .rx_parity_err(rx_parity_err),
`endif
        .rx_busy     (rx_busy)
    );
    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc++;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(negedge CLOCK_50) begin
        if (rx_valid | rx_frame_err) check("valid_ferr_exclusive", int'(rx_valid & rx_frame_err), 0);
        if (rx_frame_err) nferr++;
`ifdef UART_RX_PARITY_EN
        if (rx_parity_err) nperr++;
`endif
        if (rx_valid) begin
            nvalid++;
            last_valid_cyc = cyc;
            if (exp_q.size() > 0) check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
            else check("unexpected_valid", int'(rx_data), -1);
        end
    end
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask
    // line-level frame builder: start, LSB-first data, optional even parity, stop;
    // rst_bit >= 0 pulses reset for one cycle in the middle of that line bit
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip, input int rst_bit);
        logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop, (^d) ^ par_flip, d, 1'b0};
`else
        bits = {1'b0, stop, d, 1'b0};
`endif
        start_cyc = cyc;
        for (int i = 0; i < NBITS; i++) begin
            UART_RXD = bits[i];
            if (i == rst_bit) begin
                repeat (CPB / 2) @(posedge CLOCK_50);
                #1 reset = 1'b1;
                @(posedge CLOCK_50);
                #1 reset = 1'b0;
                repeat (CPB - CPB / 2 - 1) @(posedge CLOCK_50);
            end else repeat (CPB) @(posedge CLOCK_50);
            #1;
        end
    endtask
    task automatic mark();
        v0 = nvalid;
        f0 = nferr;
        p0 = nperr;
    endtask
    initial begin
        wait_cycles(3);
        check("reset_data", int'(rx_data), 0);
        check("reset_valid", int'(rx_valid), 0);
        check("reset_ferr", int'(rx_frame_err), 0);
        check("reset_busy", int'(rx_busy), 0);
        reset = 1'b0;
        wait_cycles(20);
        mark();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        wait_cycles(2 * CPB);
        check("a5_valid_count", nvalid - v0, 1);
        check("a5_ferr_count", nferr - f0, 0);
        check("a5_data_held", int'(rx_data), 'hA5);
        check("a5_latency", (last_valid_cyc - start_cyc >= EXP_LAT - 1 && last_valid_cyc - start_cyc <= EXP_LAT + 1) ? EXP_LAT : last_valid_cyc - start_cyc, EXP_LAT);
        mark();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        wait_cycles(2 * CPB);
        check("b2b_valid_count", nvalid - v0, 2);
        check("b2b_last_data", int'(rx_data), 'hFF);
        mark();
        UART_RXD = 1'b0;
        wait_cycles(10);
        check("glitch_busy", int'(rx_busy), 1);
        wait_cycles(90);
        UART_RXD = 1'b1;
        wait_cycles(1000);
        check("glitch_idle", int'(rx_busy), 0);
        check("glitch_valid_count", nvalid - v0, 0);
        check("glitch_ferr_count", nferr - f0, 0);
        mark();
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        wait_cycles(2000);
        check("break_busy", int'(rx_busy), 1);
        UART_RXD = 1'b1;
        wait_cycles(2 * CPB);
        check("break_idle", int'(rx_busy), 0);
        check("ferr_count", nferr - f0, 1);
        check("ferr_valid_count", nvalid - v0, 0);
        check("ferr_data_unchanged", int'(rx_data), 'hFF);
        mark();
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0, -1);
        wait_cycles(2 * CPB);
        check("after_ferr_valid_count", nvalid - v0, 1);
        mark();
        send_frame(8'hC3, 1'b1, 1'b0, 5);
        wait_cycles(2 * CPB);
        check("rst_mid_valid_count", nvalid - v0, 0);
        check("rst_mid_ferr_count", nferr - f0, 0);
        check("rst_mid_data", int'(rx_data), 0);
        check("rst_mid_busy", int'(rx_busy), 0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1'b0, -1);
        wait_cycles(2 * CPB);
        check("after_rst_valid_count", nvalid - v0, 1);
        mark();
        for (int i = 0; i < 3; i++) begin
            rnd = 8'($urandom);
            exp_q.push_back(rnd);
            send_frame(rnd, 1'b1, 1'b0, -1);
            wait_cycles($urandom_range(0, 1) * $urandom_range(1, 500));
        end
        wait_cycles(2 * CPB);
        check("rand_valid_count", nvalid - v0, 3);
`ifdef UART_RX_PARITY_EN
        mark();
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0, -1);
        wait_cycles(2 * CPB);
        check("par_ok_valid", nvalid - v0, 1);
        check("par_ok_perr", nperr - p0, 0);
        mark();
        send_frame(8'h07, 1'b1, 1'b1, -1);
        wait_cycles(2 * CPB);
        check("par_bad_valid", nvalid - v0, 0);
        check("par_bad_perr", nperr - p0, 1);
`endif
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, truncated (434 at the defaults).
REQ-003 SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port UART_RXD, input, 1 bit: asynchronous serial line, idle high, 8N1 framing.
REQ-006 SHALL have port rx_data, output, 8 bits: last received byte, LSB first on the line.
REQ-007 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data is updated.
REQ-008 SHALL have port rx_frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL have port rx_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 SHALL pass UART_RXD through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-011 SHALL implement the states IDLE, START, DATA, STOP, and WAIT_IDLE.
REQ-012 IDLE: a synchronized falling edge (1 to 0) SHALL load the bit counter with CLKS_PER_BIT/2 and enter START.
REQ-013 START: at the mid-bit count, a low sample SHALL enter DATA with bit index 0; a high sample is a glitch and SHALL return to IDLE with no output pulse.
REQ-014 DATA: each bit SHALL be sampled every CLKS_PER_BIT cycles into a shift register, LSB first; after bit index 7 the state SHALL be STOP.
REQ-015 STOP: a mid-bit high sample SHALL load rx_data and pulse rx_valid in the following cycle, then enter IDLE.
REQ-016 STOP: a mid-bit low sample SHALL pulse rx_frame_err, leave rx_data unchanged, suppress rx_valid, and enter WAIT_IDLE.
REQ-017 WAIT_IDLE SHALL hold until the synchronized line is high (break or line stuck low), then enter IDLE.
REQ-018 Because STOP returns to IDLE at mid-stop-bit, back-to-back frames with zero idle time SHALL be received without loss.
REQ-019 rx_data SHALL hold its value until the next valid frame, with no consumer handshake; the consumer must sample rx_data on rx_valid.
REQ-020 Latency from the start-bit falling edge at the pin to rx_valid SHALL be 2 sync cycles + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, within plus or minus 1.
REQ-021 rx_valid and rx_frame_err SHALL never assert in the same cycle.

Reset
REQ-022 With reset high at a clock edge, the state SHALL be IDLE, and rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_busy=0.
REQ-023 Both synchronizer flops SHALL reset to 1 (idle line), so a low line after reset is not seen as a false falling edge.
REQ-024 Reset mid-frame SHALL discard the partial byte; reception SHALL resume with the next falling edge after release.

Configuration
REQ-025 The macro UART_RX_PARITY_EN SHALL control an even-parity bit.
REQ-026 With UART_RX_PARITY_EN defined, a PARITY state SHALL sit between DATA and STOP, and an output rx_parity_err (1 bit) SHALL exist.
REQ-027 On a parity mismatch, rx_parity_err SHALL pulse with the STOP outcome and rx_valid SHALL be suppressed.
REQ-028 Without UART_RX_PARITY_EN, there SHALL be no PARITY state and no rx_parity_err port; framing is 8N1.

Structure
REQ-029 Shared package uart_pkg SHALL hold the state encoding constants, DATA_BITS=8, and the CLKS_PER_BIT computation function, for reuse by a future uart_tx.
REQ-030 The sub-module uart_baud_cnt SHALL provide a loadable down-counter with a mid/terminal tick.
REQ-031 The synchronizer SHALL stay inline in uart_rx.

Verification
REQ-032 Send 8'hA5 at 115200 baud with default parameters -> exactly one rx_valid pulse, rx_data=8'hA5, no rx_frame_err.
REQ-033 Send 8'h00 then 8'hFF back-to-back with zero idle time -> two rx_valid pulses carrying 8'h00 then 8'hFF.
REQ-034 Drive a 100-cycle low glitch on an idle line -> rx_busy pulses, then no rx_valid and no rx_frame_err; IDLE is re-entered.
REQ-035 Send 8'h3C with the stop bit low, hold the line low for 2000 cycles, then release -> one rx_frame_err, no rx_valid, rx_data unchanged; the next 8'h55 is received correctly.
REQ-036 Assert reset for 1 cycle during bit 4 of 8'hC3 -> no output for that frame, outputs equal the reset values; the next frame 8'h12 is received.
REQ-037 With UART_RX_PARITY_EN defined, send 8'h07 with parity 1 (correct) -> rx_valid; send it with parity 0 -> rx_parity_err and no rx_valid.
